// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, widths and state type for the VGA scanout controller.
// Defaults give 640x480@60 from a 25 MHz pixel clock.
package vga_timing_pkg;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;

   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;

   localparam int unsigned RGB_W = 10;
   localparam int unsigned CNT_W = 10;

   typedef enum logic {
      IDLE,
      RUN
   } vga_state_e;

endpackage

// File: rtl/vga_axis_gen.sv
// One scan axis (horizontal or vertical): position counter with wrap, plus
// active-region and active-low sync decode of the current position.
module vga_axis_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned FP     = DEF_H_FP,
   parameter int unsigned SYNC   = DEF_H_SYNC,
   parameter int unsigned BP     = DEF_H_BP
) (
   input  logic             clk50m,
   input  logic             rst,
   input  logic             clr,
   input  logic             adv,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap,
   output logic             active,
   output logic             sync_n
);

   localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

   localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
   localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACTIVE);
   localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(ACTIVE + FP);
   localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(ACTIVE + FP + SYNC);

   always_ff @(posedge clk50m) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (adv) begin
         cnt <= wrap ? '0 : cnt + CNT_W'(1);
      end
   end

   always_comb begin
      wrap   = (cnt == LAST);
      active = (cnt < ACT_END);
      sync_n = !((cnt >= SYNC_BEG) && (cnt < SYNC_END));
   end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA scanout controller: divides clk50m into the pixel clock, walks the raster
// and registers RGB, sync and blank together one pixel period after the request.
module vga_timing_ctrl
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP
) (
   input  logic               clk50m,
   input  logic               rst,
   input  logic               en,
   output logic [CNT_W-1:0]   px_x,
   output logic [CNT_W-1:0]   px_y,
   output logic               pix_req,
   input  logic [3*RGB_W-1:0] pix_rgb,
   output logic               frame_start,
   output logic               VGA_CLK,
   output logic               VGA_HS,
   output logic               VGA_VS,
   output logic               VGA_BLANK,
   output logic               VGA_SYNC,
   output logic [RGB_W-1:0]   VGA_R,
   output logic [RGB_W-1:0]   VGA_G,
   output logic [RGB_W-1:0]   VGA_B
);

   logic       phase;
   logic       tick;
   vga_state_e state_q;
   vga_state_e state_d;
   logic       run;

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             h_wrap, v_wrap;
   logic             h_act, v_act;
   logic             hs0, vs0;
   logic             h_adv, v_adv;

   always_ff @(posedge clk50m) begin
      if (rst) begin
         phase <= 1'b0;
      end else begin
         phase <= ~phase;
      end
   end

   assign tick = phase;

   always_ff @(posedge clk50m) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Stopping is only honoured on the last pixel of a frame so frames never truncate.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (tick && en) state_d = RUN;
         RUN:  if (tick && !en && h_wrap && v_wrap) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign run   = (state_q == RUN);
   assign h_adv = tick && run;
   assign v_adv = h_adv && h_wrap;

   vga_axis_gen #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP)
   ) u_h_axis (
      .clk50m (clk50m),
      .rst    (rst),
      .clr    (!run),
      .adv    (h_adv),
      .cnt    (h_cnt),
      .wrap   (h_wrap),
      .active (h_act),
      .sync_n (hs0)
   );

   vga_axis_gen #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP)
   ) u_v_axis (
      .clk50m (clk50m),
      .rst    (rst),
      .clr    (!run),
      .adv    (v_adv),
      .cnt    (v_cnt),
      .wrap   (v_wrap),
      .active (v_act),
      .sync_n (vs0)
   );

   always_comb begin
      px_x        = h_cnt;
      px_y        = v_cnt;
      pix_req     = run && h_act && v_act;
      frame_start = run && !phase && (h_cnt == '0) && (v_cnt == '0);
   end

   // RGB, sync and blank share this one stage so they stay exactly aligned.
   always_ff @(posedge clk50m) begin
      if (rst) begin
         VGA_R     <= '0;
         VGA_G     <= '0;
         VGA_B     <= '0;
         VGA_HS    <= 1'b1;
         VGA_VS    <= 1'b1;
         VGA_BLANK <= 1'b0;
      end else if (tick) begin
         if (run) begin
            VGA_R     <= pix_req ? pix_rgb[2*RGB_W +: RGB_W] : '0;
            VGA_G     <= pix_req ? pix_rgb[RGB_W +: RGB_W]   : '0;
            VGA_B     <= pix_req ? pix_rgb[0 +: RGB_W]       : '0;
            VGA_HS    <= hs0;
            VGA_VS    <= vs0;
            VGA_BLANK <= pix_req;
         end else begin
            VGA_R     <= '0;
            VGA_G     <= '0;
            VGA_B     <= '0;
            VGA_HS    <= 1'b1;
            VGA_VS    <= 1'b1;
            VGA_BLANK <= 1'b0;
         end
      end
   end

   assign VGA_CLK  = phase;
   assign VGA_SYNC = 1'b0;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboarded bench for vga_timing_ctrl on a reduced raster: a frame-position
// model predicts every pin each cycle, plus interval checks on sync/blank/frame pulses.
module tb_vga_timing_ctrl;

   localparam int unsigned HA  = 16;
   localparam int unsigned HFP = 4;
   localparam int unsigned HSW = 6;
   localparam int unsigned HBP = 6;
   localparam int unsigned VA  = 12;
   localparam int unsigned VFP = 2;
   localparam int unsigned VSW = 2;
   localparam int unsigned VBP = 3;
   localparam int unsigned HT  = HA + HFP + HSW + HBP;
   localparam int unsigned VT  = VA + VFP + VSW + VBP;
   localparam int unsigned FT  = HT * VT;

   logic        clk50m = 1'b0;
   logic        rst;
   logic        en;
   logic [29:0] pix_rgb;
   logic [9:0]  px_x, px_y;
   logic        pix_req, frame_start;
   logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC;
   logic [9:0]  VGA_R, VGA_G, VGA_B;

   vga_timing_ctrl #(
      .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
      .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP)
   ) dut (
      .clk50m      (clk50m),
      .rst         (rst),
      .en          (en),
      .px_x        (px_x),
      .px_y        (px_y),
      .pix_req     (pix_req),
      .pix_rgb     (pix_rgb),
      .frame_start (frame_start),
      .VGA_CLK     (VGA_CLK),
      .VGA_HS      (VGA_HS),
      .VGA_VS      (VGA_VS),
      .VGA_BLANK   (VGA_BLANK),
      .VGA_SYNC    (VGA_SYNC),
      .VGA_R       (VGA_R),
      .VGA_G       (VGA_G),
      .VGA_B       (VGA_B)
   );

   always #5 clk50m = ~clk50m;

   typedef struct {
      logic       vclk, hs, vs, blank, req, fs;
      logic [9:0] x, y, r, g, b;
   } exp_t;

   exp_t q[$];

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   bit          align    = 1'b1;
   bit          steady   = 1'b0;

   // Model: a running flag and a linear pixel index within the frame.
   bit          m_phase = 1'b0;
   bit          m_run   = 1'b0;
   int unsigned m_pos   = 0;
   logic [9:0]  m_r = '0, m_g = '0, m_b = '0;
   logic        m_hs = 1'b1, m_vs = 1'b1, m_blank = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
      end
   endtask

   function automatic bit in_sync(input int unsigned p, input int unsigned a,
                                  input int unsigned fp, input int unsigned s);
      return (p >= a + fp) && (p < a + fp + s);
   endfunction

   initial begin
      exp_t        e;
      int unsigned h, v;
      bit          req;
      forever begin
         @(posedge clk50m);
         h   = m_pos % HT;
         v   = m_pos / HT;
         req = m_run && (h < HA) && (v < VA);
         if (rst) begin
            m_phase = 1'b0; m_run = 1'b0; m_pos = 0;
            m_r = '0; m_g = '0; m_b = '0;
            m_hs = 1'b1; m_vs = 1'b1; m_blank = 1'b0;
         end else begin
            if (m_phase) begin
               if (m_run) begin
                  m_r     = req ? pix_rgb[29:20] : 10'd0;
                  m_g     = req ? pix_rgb[19:10] : 10'd0;
                  m_b     = req ? pix_rgb[9:0]   : 10'd0;
                  m_hs    = !in_sync(h, HA, HFP, HSW);
                  m_vs    = !in_sync(v, VA, VFP, VSW);
                  m_blank = req;
                  if (m_pos == FT - 1 && !en) begin
                     m_run = 1'b0;
                     m_pos = 0;
                  end else begin
                     m_pos = (m_pos + 1) % FT;
                  end
               end else begin
                  m_r = '0; m_g = '0; m_b = '0;
                  m_hs = 1'b1; m_vs = 1'b1; m_blank = 1'b0;
                  if (en) m_run = 1'b1;
               end
            end
            m_phase = !m_phase;
         end
         e.vclk  = m_phase;
         e.hs    = m_hs;
         e.vs    = m_vs;
         e.blank = m_blank;
         e.r     = m_r;
         e.g     = m_g;
         e.b     = m_b;
         e.x     = 10'(m_pos % HT);
         e.y     = 10'(m_pos / HT);
         e.req   = m_run && ((m_pos % HT) < HA) && ((m_pos / HT) < VA);
         e.fs    = m_run && !m_phase && (m_pos == 0);
         q.push_back(e);
      end
   end

   // Upstream pixel source: coordinate pattern or random data per request.
   initial begin
      pix_rgb = '0;
      forever begin
         @(posedge clk50m);
         #1;
         if (align) pix_rgb = {10'(m_pos % HT), 10'(m_pos / HT), 10'h3FF};
         else       pix_rgb = 30'($urandom);
      end
   end

   initial begin
      exp_t        e;
      int unsigned cyc = 0;
      int unsigned t_hr = 0, t_hf = 0, t_vf = 0, t_fs = 0, t_br = 0;
      bit          ok_hr = 0, ok_hf = 0, ok_vf = 0, ok_fs = 0, ok_br = 0;
      logic        p_hs = 1'b1, p_vs = 1'b1, p_fs = 1'b0, p_bl = 1'b0;
      forever begin
         @(negedge clk50m);
         cyc++;
         if (q.size() != 0) begin
            e = q.pop_front();
            check("VGA_CLK",     32'(VGA_CLK),     32'(e.vclk));
            check("VGA_HS",      32'(VGA_HS),      32'(e.hs));
            check("VGA_VS",      32'(VGA_VS),      32'(e.vs));
            check("VGA_BLANK",   32'(VGA_BLANK),   32'(e.blank));
            check("VGA_SYNC",    32'(VGA_SYNC),    32'd0);
            check("VGA_R",       32'(VGA_R),       32'(e.r));
            check("VGA_G",       32'(VGA_G),       32'(e.g));
            check("VGA_B",       32'(VGA_B),       32'(e.b));
            check("px_x",        32'(px_x),        32'(e.x));
            check("px_y",        32'(px_y),        32'(e.y));
            check("pix_req",     32'(pix_req),     32'(e.req));
            check("frame_start", 32'(frame_start), 32'(e.fs));
         end
         if (steady) begin
            if (!p_hs && VGA_HS) begin
               if (ok_hf) check("hs_low_cycles", cyc - t_hf, 2 * HSW);
               if (ok_hr) check("hs_period_cycles", cyc - t_hr, 2 * HT);
               t_hr = cyc; ok_hr = 1;
            end
            if (p_hs && !VGA_HS) begin t_hf = cyc; ok_hf = 1; end
            if (!p_vs && VGA_VS && ok_vf) check("vs_low_cycles", cyc - t_vf, 2 * VSW * HT);
            if (p_vs && !VGA_VS) begin t_vf = cyc; ok_vf = 1; end
            if (!p_fs && frame_start) begin
               if (ok_fs) check("frame_period_cycles", cyc - t_fs, 2 * FT);
               t_fs = cyc; ok_fs = 1;
            end
            if (!p_bl && VGA_BLANK) begin t_br = cyc; ok_br = 1; end
            if (p_bl && !VGA_BLANK && ok_br) check("blank_high_cycles", cyc - t_br, 2 * HA);
         end else begin
            ok_hr = 0; ok_hf = 0; ok_vf = 0; ok_fs = 0; ok_br = 0;
         end
         p_hs = VGA_HS; p_vs = VGA_VS; p_fs = frame_start; p_bl = VGA_BLANK;
      end
   end

   task automatic wait_pos(input int unsigned target);
      for (int unsigned i = 0; i < 4 * FT; i++) begin
         @(posedge clk50m);
         #1;
         if (m_run && m_pos == target) return;
      end
      n_checks++;
      n_fail++;
      $display("FAIL wait_pos: position %0d not reached, required within %0d cycles", target, 4 * FT);
   endtask

   task automatic wait_idle();
      for (int unsigned i = 0; i < 4 * FT; i++) begin
         @(posedge clk50m);
         #1;
         if (!m_run) return;
      end
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: still running, required idle within %0d cycles", 4 * FT);
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b1;
      repeat (3) @(posedge clk50m);
      #1;
      rst = 1'b0;

      // Continuous run with coordinate pattern and interval measurements.
      steady = 1'b1;
      repeat (3 * 2 * FT + 20) @(posedge clk50m);
      #1;
      steady = 1'b0;

      // Graceful stop mid-frame, idle hold, restart.
      align = 1'b0;
      wait_pos(5 * HT + 3);
      en = 1'b0;
      wait_idle();
      repeat (60) @(posedge clk50m);
      #1;
      en = 1'b1;
      repeat (2 * FT) @(posedge clk50m);
      #1;

      // Mid-frame en pulse-off has no effect.
      wait_pos(3 * HT + 7);
      en = 1'b0;
      repeat (9) @(posedge clk50m);
      #1;
      en = 1'b1;

      // Reset in the middle of a visible line.
      wait_pos(5 * HT + 10);
      rst = 1'b1;
      @(posedge clk50m);
      #1;
      rst = 1'b0;
      repeat (FT) @(posedge clk50m);
      #1;

      // Random run requests.
      for (int k = 0; k < 60; k++) begin
         en = ($urandom_range(0, 3) != 0);
         repeat ($urandom_range(20, 120)) @(posedge clk50m);
         #1;
      end

      en = 1'b1;
      repeat (2 * FT) @(posedge clk50m);
      @(negedge clk50m);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
